// File: rtl/dtfag_rom_pkg.sv
// Shared definitions for the DTFAG ROMQ twiddle fetch path.
//   - fetch_state_e : sequencer state encoding
//   - idx_split     : splits a twiddle index into {word address, half bit}
//   - D_W / ADDR_W / IDX_W : default widths of the twiddle store
package dtfag_rom_pkg;

   localparam int D_W    = 64;
   localparam int ADDR_W = 8;
   localparam int IDX_W  = ADDR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              half;
   } idx_split_t;

   // half = 1 selects the high (HA) half of the ROM word, 0 the low (LA) half
   function automatic idx_split_t idx_split(input logic [IDX_W-1:0] idx);
      idx_split_t r;
      r.addr = idx[IDX_W-1:1];
      r.half = idx[0];
      return r;
   endfunction

endpackage

// File: rtl/rom_lat_pipe.sv
// LAT-stage delay line matching the ROM read latency.
// Carries {issue, half0, half1} so the half-select and valid flag arrive
// in the same cycle as the ROM read data.
//   clk    in   clock
//   rst_n  in   asynchronous active-low clear (drops in-flight reads)
//   d      in   W-bit value entering the line
//   q      out  value after LAT cycles
module rom_lat_pipe #(
   parameter int LAT = 1,
   parameter int W   = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stage_q [LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= d;
         for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q = stage_q[LAT-1];

endmodule

// File: rtl/rom_q_fetch_ctrl.sv
// Dual-bank ROMQ twiddle fetch sequencer.
// Walks a strided twiddle index sequence, issues one read per cycle to
// banks B0/B1, tracks the ROM latency and delivers the selected HA/LA
// halves as two twiddles per cycle.
//   clk, rst_n               clock, async active-low reset
//   start                    command strobe (accepted only when idle)
//   base_idx, stride, len    command: first B0 index, index step, pair count
//   busy, done               command in progress / one-cycle completion
//   rom_ce, rom_b*_addr      shared read enable and bank word addresses
//   rom_b0_d, rom_b1_d       double-width ROM read data
//   tf0_out, tf1_out         selected twiddles, qualified by tf_valid
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; len = 0 just pulses done
// ST_RUN   | one read issued per cycle until len issues are done
// ST_DRAIN | last reads travelling through the latency pipe; done on exit
module rom_q_fetch_ctrl #(
   parameter int D_W     = dtfag_rom_pkg::D_W,
   parameter int ADDR_W  = dtfag_rom_pkg::ADDR_W,
   parameter int IDX_W   = ADDR_W + 1,
   parameter int LEN_W   = 9,
   parameter int ROM_LAT = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [IDX_W-1:0]   base_idx,
   input  logic [IDX_W-1:0]   stride,
   input  logic [LEN_W-1:0]   len,
   output logic               busy,
   output logic               done,
   output logic               rom_ce,
   output logic [ADDR_W-1:0]  rom_b0_addr,
   output logic [ADDR_W-1:0]  rom_b1_addr,
   input  logic [2*D_W-1:0]   rom_b0_d,
   input  logic [2*D_W-1:0]   rom_b1_d,
   output logic [D_W-1:0]     tf0_out,
   output logic [D_W-1:0]     tf1_out,
   output logic               tf_valid
);

   import dtfag_rom_pkg::*;

   localparam int DRN_W = $clog2(ROM_LAT + 1);

   fetch_state_e      state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDX_W-1:0]  stride_q, stride_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [DRN_W-1:0]  drain_q, drain_d;
   logic              ce_q, ce_d;
   logic [ADDR_W-1:0] a0_q, a0_d, a1_q, a1_d;
   logic              h0_q, h0_d, h1_q, h1_d;
   logic              done_q, done_d;
   logic              tfv_q, tfv_d;
   logic [D_W-1:0]    tf0_q, tf0_d, tf1_q, tf1_d;

   logic              iss;
   logic [IDX_W-1:0]  iss_k, iss_s, iss_j;
   logic              p_issue, p_h0, p_h1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         stride_q <= '0;
         rem_q    <= '0;
         drain_q  <= '0;
         ce_q     <= 1'b0;
         a0_q     <= '0;
         a1_q     <= '0;
         h0_q     <= 1'b0;
         h1_q     <= 1'b0;
         done_q   <= 1'b0;
         tfv_q    <= 1'b0;
         tf0_q    <= '0;
         tf1_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         stride_q <= stride_d;
         rem_q    <= rem_d;
         drain_q  <= drain_d;
         ce_q     <= ce_d;
         a0_q     <= a0_d;
         a1_q     <= a1_d;
         h0_q     <= h0_d;
         h1_q     <= h1_d;
         done_q   <= done_d;
         tfv_q    <= tfv_d;
         tf0_q    <= tf0_d;
         tf1_q    <= tf1_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      stride_d = stride_q;
      rem_d    = rem_q;
      drain_d  = drain_q;
      ce_d     = 1'b0;
      a0_d     = a0_q;
      a1_d     = a1_q;
      h0_d     = h0_q;
      h1_d     = h1_q;
      done_d   = 1'b0;
      iss      = 1'b0;
      iss_k    = idx_q;
      iss_s    = stride_q;
      iss_j    = '0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d  = ST_RUN;
                  stride_d = stride;
                  rem_d    = len - LEN_W'(1);
                  iss      = 1'b1;
                  iss_k    = base_idx;
                  iss_s    = stride;
               end
            end
         end
         ST_RUN: begin
            if (rem_q == '0) begin
               state_d = ST_DRAIN;
               drain_d = DRN_W'(ROM_LAT);
            end else begin
               rem_d = rem_q - LEN_W'(1);
               iss   = 1'b1;
            end
         end
         ST_DRAIN: begin
            // drain_q counts down to the cycle where the final pair is
            // presented; done is registered one cycle ahead of that
            if (drain_q == DRN_W'(1)) done_d = 1'b1;
            if (drain_q == '0) state_d = ST_IDLE;
            else               drain_d = drain_q - DRN_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase

      iss_j = iss_k + iss_s;
      if (iss) begin
         ce_d  = 1'b1;
         a0_d  = iss_k[IDX_W-1:1];
         h0_d  = iss_k[0];
         a1_d  = iss_j[IDX_W-1:1];
         h1_d  = iss_j[0];
         idx_d = iss_k + {iss_s[IDX_W-2:0], 1'b0};
      end
   end

   rom_lat_pipe #(
      .LAT (ROM_LAT),
      .W   (3)
   ) u_lat_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({ce_q, h0_q, h1_q}),
      .q     ({p_issue, p_h0, p_h1})
   );

   always_comb begin
      tfv_d = p_issue;
      tf0_d = tf0_q;
      tf1_d = tf1_q;
      if (p_issue) begin
         tf0_d = p_h0 ? rom_b0_d[2*D_W-1:D_W] : rom_b0_d[D_W-1:0];
         tf1_d = p_h1 ? rom_b1_d[2*D_W-1:D_W] : rom_b1_d[D_W-1:0];
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign rom_ce      = ce_q;
   assign rom_b0_addr = a0_q;
   assign rom_b1_addr = a1_q;
   assign tf_valid    = tfv_q;
   assign tf0_out     = tf0_q;
   assign tf1_out     = tf1_q;

endmodule

// File: tb/tb_rom_q_fetch_ctrl.sv
module tb_rom_q_fetch_ctrl;

   localparam int D_W    = 64;
   localparam int ADDR_W = 8;
   localparam int IDX_W  = 9;
   localparam int LEN_W  = 9;
   localparam int N      = 2048;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [IDX_W-1:0] base_idx = '0;
   logic [IDX_W-1:0] stride = '0;
   logic [LEN_W-1:0] len = '0;

   logic [1:0]         busy_v, done_v, ce_v, tfv_v;
   logic [ADDR_W-1:0]  a0_v [2];
   logic [ADDR_W-1:0]  a1_v [2];
   logic [2*D_W-1:0]   d0_v [2];
   logic [2*D_W-1:0]   d1_v [2];
   logic [D_W-1:0]     tf0_v [2];
   logic [D_W-1:0]     tf1_v [2];

   always #5 clk = ~clk;

   rom_q_fetch_ctrl #(.ROM_LAT(1)) dut_l1 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .base_idx(base_idx), .stride(stride), .len(len),
      .busy(busy_v[0]), .done(done_v[0]), .rom_ce(ce_v[0]),
      .rom_b0_addr(a0_v[0]), .rom_b1_addr(a1_v[0]),
      .rom_b0_d(d0_v[0]), .rom_b1_d(d1_v[0]),
      .tf0_out(tf0_v[0]), .tf1_out(tf1_v[0]), .tf_valid(tfv_v[0])
   );

   rom_q_fetch_ctrl #(.ROM_LAT(3)) dut_l3 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .base_idx(base_idx), .stride(stride), .len(len),
      .busy(busy_v[1]), .done(done_v[1]), .rom_ce(ce_v[1]),
      .rom_b0_addr(a0_v[1]), .rom_b1_addr(a1_v[1]),
      .rom_b0_d(d0_v[1]), .rom_b1_d(d1_v[1]),
      .tf0_out(tf0_v[1]), .tf1_out(tf1_v[1]), .tf_valid(tfv_v[1])
   );

   // ROM content: every (bank, address, half) gives a distinct twiddle
   function automatic logic [D_W-1:0] tw(input int bank, input int addr, input int half);
      return {16'hC0DE, 8'(bank), 8'(half), 24'(addr * 37 + 5), 8'(addr)};
   endfunction

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   // Behavioural ROM banks: fixed read latency, junk when not enabled
   for (genvar g = 0; g < 2; g++) begin : g_rom
      localparam int L = (g == 0) ? 1 : 3;
      logic [2*D_W-1:0] p0 [L];
      logic [2*D_W-1:0] p1 [L];
      always @(posedge clk) begin
         p0[0] <= ce_v[g] ? {tw(0, int'(a0_v[g]), 1), tw(0, int'(a0_v[g]), 0)}
                          : {$urandom, $urandom, $urandom, $urandom};
         p1[0] <= ce_v[g] ? {tw(1, int'(a1_v[g]), 1), tw(1, int'(a1_v[g]), 0)}
                          : {$urandom, $urandom, $urandom, $urandom};
         for (int i = 1; i < L; i++) begin
            p0[i] <= p0[i-1];
            p1[i] <= p1[i-1];
         end
      end
      assign d0_v[g] = p0[L-1];
      assign d1_v[g] = p1[L-1];
   end

   // Expected behaviour per cycle, per latency variant
   bit               e_busy [2][N];
   bit               e_done [2][N];
   bit               e_ce   [2][N];
   bit               e_tfv  [2][N];
   logic [ADDR_W-1:0] e_a0  [2][N];
   logic [ADDR_W-1:0] e_a1  [2][N];
   logic [D_W-1:0]   e_tf0  [2][N];
   logic [D_W-1:0]   e_tf1  [2][N];
   int               free_c [2];
   logic [D_W-1:0]   last0  [2];
   logic [D_W-1:0]   last1  [2];

   int cyc    = 0;
   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset(input int d, input int c);
      for (int t = c; t < N; t++) begin
         e_busy[d][t] = 0; e_done[d][t] = 0; e_ce[d][t] = 0; e_tfv[d][t] = 0;
      end
      free_c[d] = c;
      last0[d]  = '0;
      last1[d]  = '0;
   endtask

   task automatic model_accept(input int d, input int c, input int b, input int s, input int l);
      int lat, k, j;
      lat = lat_of(d);
      if (l == 0) begin
         e_done[d][c+1] = 1;
         free_c[d] = c + 1;
         return;
      end
      for (int i = 0; i < l; i++) begin
         k = (b + 2 * i * s) % (1 << IDX_W);
         j = (k + s) % (1 << IDX_W);
         e_ce[d][c+1+i]       = 1;
         e_a0[d][c+1+i]       = ADDR_W'(k / 2);
         e_a1[d][c+1+i]       = ADDR_W'(j / 2);
         e_tfv[d][c+lat+2+i]  = 1;
         e_tf0[d][c+lat+2+i]  = tw(0, k / 2, k % 2);
         e_tf1[d][c+lat+2+i]  = tw(1, j / 2, j % 2);
      end
      for (int t = c + 1; t <= c + lat + 1 + l; t++) e_busy[d][t] = 1;
      e_done[d][c+lat+1+l] = 1;
      free_c[d] = c + lat + 2 + l;
   endtask

   // One clock cycle: drive, update model, check mid-cycle, advance
   task automatic tick(input logic st, input int b, input int s, input int l, input logic rn);
      rst_n    = rn;
      start    = st;
      base_idx = IDX_W'(b);
      stride   = IDX_W'(s);
      len      = LEN_W'(l);
      for (int d = 0; d < 2; d++) begin
         if (!rn) model_reset(d, cyc);
         else if (st && cyc >= free_c[d]) model_accept(d, cyc, b, s, l);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         string p;
         p = $sformatf("lat%0d c%0d", lat_of(d), cyc);
         chk({p, " busy"}, 64'(busy_v[d]), 64'(e_busy[d][cyc]));
         chk({p, " done"}, 64'(done_v[d]), 64'(e_done[d][cyc]));
         chk({p, " rom_ce"}, 64'(ce_v[d]), 64'(e_ce[d][cyc]));
         if (e_ce[d][cyc]) begin
            chk({p, " b0_addr"}, 64'(a0_v[d]), 64'(e_a0[d][cyc]));
            chk({p, " b1_addr"}, 64'(a1_v[d]), 64'(e_a1[d][cyc]));
         end
         if (!rn) begin
            chk({p, " rst b0_addr"}, 64'(a0_v[d]), 64'd0);
            chk({p, " rst b1_addr"}, 64'(a1_v[d]), 64'd0);
         end
         chk({p, " tf_valid"}, 64'(tfv_v[d]), 64'(e_tfv[d][cyc]));
         if (e_tfv[d][cyc]) begin
            last0[d] = e_tf0[d][cyc];
            last1[d] = e_tf1[d][cyc];
         end
         chk({p, " tf0"}, tf0_v[d], last0[d]);
         chk({p, " tf1"}, tf1_v[d], last1[d]);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, $urandom_range(0, 511), $urandom_range(0, 511),
                      $urandom_range(0, 20), 1'b1);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) model_reset(d, 0);
      @(posedge clk);
      #1;
      repeat (3) tick(1'b0, 0, 0, 0, 1'b0);
      idle(2);

      // base 5, stride 1, len 2
      tick(1'b1, 5, 1, 2, 1'b1);
      idle(10);

      // zero-length command
      tick(1'b1, 7, 3, 0, 1'b1);
      idle(3);

      // index wrap at the top of the index space
      tick(1'b1, 510, 1, 2, 1'b1);
      idle(10);

      // start held every cycle during a len=4 burst
      tick(1'b1, 100, 7, 4, 1'b1);
      repeat (6) tick(1'b1, $urandom_range(0, 511), $urandom_range(0, 511),
                      $urandom_range(0, 20), 1'b1);
      idle(10);

      // reset in issue cycle 2 of a len=8 burst
      tick(1'b1, 33, 5, 8, 1'b1);
      idle(1);
      tick(1'b0, 0, 0, 0, 1'b0);
      tick(1'b0, 0, 0, 0, 1'b0);
      idle(15);

      // len=5 burst
      tick(1'b1, 200, 9, 5, 1'b1);
      idle(14);

      // random commands with occasional reset
      repeat (400) begin
         tick(($urandom_range(0, 2) == 0), $urandom_range(0, 511), $urandom_range(0, 511),
              $urandom_range(0, 20), ($urandom_range(0, 149) != 0));
      end
      idle(30);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
